// File: rtl/traffic_light_fsm.sv
// Two-road intersection controller: NS main road rests on green, EW side road and
// pedestrian walk are served on request with timed yellow and all-red clearances.
module traffic_light_fsm #(
    parameter int NS_GREEN_CYC = 8,
    parameter int EW_GREEN_CYC = 5,
    parameter int YELLOW_CYC   = 2,
    parameter int ALLRED_CYC   = 1,
    parameter int WALK_CYC     = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       ew_car,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        CLEAR_A   = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        CLEAR_B   = 3'd5,
        PED_WALK  = 3'd6,
        PED_CLEAR = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Final timer value of each phase (dwell - 1).
    localparam logic [CNT_W-1:0] NS_GREEN_LAST = CNT_W'(NS_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] EW_GREEN_LAST = CNT_W'(EW_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST   = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST   = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LAST     = CNT_W'(WALK_CYC - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic [CNT_W-1:0] dwell_last;
    logic             done;
    logic             ew_pending;
    logic             ew_pending_next;
    logic             ped_pending_next;
    logic [2:0]       ns_light_next;
    logic [2:0]       ew_light_next;
    logic             walk_next;

    assign phase = state;

    always_comb begin
        dwell_last = ALLRED_LAST;
        case (state)
            NS_GREEN:             dwell_last = NS_GREEN_LAST;
            NS_YELLOW, EW_YELLOW: dwell_last = YELLOW_LAST;
            EW_GREEN:             dwell_last = EW_GREEN_LAST;
            PED_WALK:             dwell_last = WALK_LAST;
            default:              dwell_last = ALLRED_LAST;
        endcase
    end

    assign done = (timer == dwell_last);

    always_comb begin
        state_next = state;
        case (state)
            NS_GREEN:  if (done && (ew_pending || ped_pending)) state_next = NS_YELLOW;
            NS_YELLOW: if (done) state_next = CLEAR_A;
            CLEAR_A:   if (done) state_next = ew_pending ? EW_GREEN : PED_WALK;
            EW_GREEN:  if (done) state_next = EW_YELLOW;
            EW_YELLOW: if (done) state_next = CLEAR_B;
            CLEAR_B:   if (done) state_next = ped_pending ? PED_WALK : NS_GREEN;
            PED_WALK:  if (done) state_next = PED_CLEAR;
            PED_CLEAR: if (done) state_next = NS_GREEN;
            default:   state_next = NS_GREEN;
        endcase
    end

    // Timer restarts on every phase change and holds at the last value (NS green rest).
    always_comb begin
        timer_next = timer;
        if (state_next != state) begin
            timer_next = '0;
        end else if (!done) begin
            timer_next = timer + 1'b1;
        end
    end

    // Requests arriving while being served are dropped; entering service clears the flag.
    always_comb begin
        ped_pending_next = ped_pending | (ped_req && (state != PED_WALK));
        ew_pending_next  = ew_pending | (ew_car && (state != EW_GREEN));
        if (state_next == PED_WALK && state != PED_WALK) begin
            ped_pending_next = 1'b0;
        end
        if (state_next == EW_GREEN && state != EW_GREEN) begin
            ew_pending_next = 1'b0;
        end
    end

    // Lamps decode the next state so the registered lamps line up with phase.
    always_comb begin
        ns_light_next = LAMP_RED;
        ew_light_next = LAMP_RED;
        walk_next     = 1'b0;
        case (state_next)
            NS_GREEN:  ns_light_next = LAMP_GREEN;
            NS_YELLOW: ns_light_next = LAMP_YELLOW;
            EW_GREEN:  ew_light_next = LAMP_GREEN;
            EW_YELLOW: ew_light_next = LAMP_YELLOW;
            PED_WALK:  walk_next     = 1'b1;
            default: begin
                ns_light_next = LAMP_RED;
                ew_light_next = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= NS_GREEN;
            timer       <= '0;
            ns_light    <= LAMP_GREEN;
            ew_light    <= LAMP_RED;
            walk        <= 1'b0;
            ped_pending <= 1'b0;
            ew_pending  <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            ns_light    <= ns_light_next;
            ew_light    <= ew_light_next;
            walk        <= walk_next;
            ped_pending <= ped_pending_next;
            ew_pending  <= ew_pending_next;
        end
    end

endmodule
